// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Issue sequencer for the floating-point unit. Takes one FP instruction at a
// time from decode through a valid/ready handshake and classifies its latency.
// It drives the latched fields to the FPU for that many cycles, then sequences
// the single FP register-file write port. An FP load always wins that port.
//
// Configuration macro: FPU_CTRL_DIVSQRT_EN
//   defined   : fdiv (funct7[6:2]=5'h03) and fsqrt (5'h0B) are legal.
//   undefined : both are dropped as illegal, and DIV_LAT/SQRT_LAT are ignored.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready        instruction handshake from decode
//   i_ops/i_funct7/i_funct3  instruction fields
//   i_rs1_a/i_rs2_a/i_rd_a   register addresses
//   o_ops .. o_rd_a          registered copies driven to the FPU datapath
//   o_issue                  pulse in the first execute cycle
//   o_busy                   controller is not idle
//   i_ld_valid               an FP load owns the FP write port this cycle
//   o_wb_fp / o_wb_int       FP / integer result writeback strobes
//   o_illegal                pulse after an unsupported op was dropped
//   i_flush                  synchronous abort
module fpu_issue_ctrl #(
  parameter int unsigned ADD_LAT  = 1,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_LAT  = 12,
  parameter int unsigned SQRT_LAT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [6:0] i_ops,
  input  logic [6:0] i_funct7,
  input  logic [2:0] i_funct3,
  input  logic [4:0] i_rs1_a,
  input  logic [4:0] i_rs2_a,
  input  logic [4:0] i_rd_a,
  output logic [6:0] o_ops,
  output logic [6:0] o_funct7,
  output logic [2:0] o_funct3,
  output logic [4:0] o_rs1_a,
  output logic [4:0] o_rs2_a,
  output logic [4:0] o_rd_a,
  output logic       o_issue,
  output logic       o_busy,
  input  logic       i_ld_valid,
  output logic       o_wb_fp,
  output logic       o_wb_int,
  output logic       o_illegal,
  input  logic       i_flush
);

`ifdef FPU_CTRL_DIVSQRT_EN
  localparam bit DIVSQRT_EN = 1'b1;
`else
  localparam bit DIVSQRT_EN = 1'b0;
`endif

  localparam logic [4:0] ADD_L  = 5'(ADD_LAT);
  localparam logic [4:0] MUL_L  = 5'(MUL_LAT);
  localparam logic [4:0] DIV_L  = 5'(DIV_LAT);
  localparam logic [4:0] SQRT_L = 5'(SQRT_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       is_int_q, is_int_d;
  logic       issue_q, issue_d;
  logic       illegal_q, illegal_d;
  logic [6:0] ops_q, ops_d;
  logic [6:0] funct7_q, funct7_d;
  logic [2:0] funct3_q, funct3_d;
  logic [4:0] rs1_q, rs1_d;
  logic [4:0] rs2_q, rs2_d;
  logic [4:0] rd_q, rd_d;

  logic       dec_legal;
  logic       dec_int;
  logic [4:0] dec_lat;
  logic       accept;

  // Decode the offered instruction into legality, destination class and
  // latency. Div/sqrt latencies are always computed; only their legality
  // depends on the build option.
  always_comb begin
    dec_legal = 1'b0;
    dec_int   = 1'b0;
    dec_lat   = 5'd1;
    if (i_ops == 7'h53) begin
      case (i_funct7[6:2])
        5'h00, 5'h01: begin dec_legal = 1'b1; dec_lat = ADD_L; end
        5'h02:        begin dec_legal = 1'b1; dec_lat = MUL_L; end
        5'h03:        begin dec_legal = DIVSQRT_EN; dec_lat = DIV_L; end
        5'h0B:        begin dec_legal = DIVSQRT_EN; dec_lat = SQRT_L; end
        5'h14, 5'h18, 5'h1C: begin dec_legal = 1'b1; dec_int = 1'b1; end
        default:      ;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE) && !i_flush;
  assign accept  = i_valid && o_ready;

  // Next-state and writeback strobes. Flush is applied last so it overrides
  // every transition and suppresses the strobes in its own cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_int_d  = is_int_q;
    issue_d   = 1'b0;
    illegal_d = 1'b0;
    ops_d     = ops_q;
    funct7_d  = funct7_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    o_wb_fp   = 1'b0;
    o_wb_int  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            ops_d    = i_ops;
            funct7_d = i_funct7;
            funct3_d = i_funct3;
            rs1_d    = i_rs1_a;
            rs2_d    = i_rs2_a;
            rd_d     = i_rd_a;
            is_int_d = dec_int;
            cnt_d    = dec_lat - 5'd1;
            issue_d  = 1'b1;
            state_d  = EXEC;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 5'd0) begin
          state_d = WB;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      WB: begin
        // A load on the FP port stalls an FP result; integer results use a
        // separate path and never wait.
        if (is_int_q) begin
          o_wb_int = 1'b1;
          state_d  = IDLE;
        end else begin
          o_wb_fp = !i_ld_valid;
          if (!i_ld_valid) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_flush) begin
      state_d  = IDLE;
      cnt_d    = 5'd0;
      issue_d  = 1'b0;
      o_wb_fp  = 1'b0;
      o_wb_int = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      is_int_q  <= 1'b0;
      issue_q   <= 1'b0;
      illegal_q <= 1'b0;
      ops_q     <= 7'd0;
      funct7_q  <= 7'd0;
      funct3_q  <= 3'd0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_int_q  <= is_int_d;
      issue_q   <= issue_d;
      illegal_q <= illegal_d;
      ops_q     <= ops_d;
      funct7_q  <= funct7_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
    end
  end

  // The issue pulse is masked by a flush landing in the first execute cycle.
  assign o_issue   = issue_q && !i_flush;
  assign o_illegal = illegal_q;
  assign o_busy    = (state_q != IDLE);
  assign o_ops     = ops_q;
  assign o_funct7  = funct7_q;
  assign o_funct3  = funct3_q;
  assign o_rs1_a   = rs1_q;
  assign o_rs2_a   = rs2_q;
  assign o_rd_a    = rd_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
// Directed self-checking bench for fpu_issue_ctrl. Inputs change 1 time unit
// after a rising edge; outputs are sampled one unit later.
module tb_fpu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, o_ready;
  logic [6:0] i_ops, i_funct7, o_ops, o_funct7;
  logic [2:0] i_funct3, o_funct3;
  logic [4:0] i_rs1_a, i_rs2_a, i_rd_a, o_rs1_a, o_rs2_a, o_rd_a;
  logic       o_issue, o_busy, i_ld_valid, o_wb_fp, o_wb_int, o_illegal, i_flush;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctrl dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ops(i_ops), .i_funct7(i_funct7), .i_funct3(i_funct3),
    .i_rs1_a(i_rs1_a), .i_rs2_a(i_rs2_a), .i_rd_a(i_rd_a),
    .o_ops(o_ops), .o_funct7(o_funct7), .o_funct3(o_funct3),
    .o_rs1_a(o_rs1_a), .o_rs2_a(o_rs2_a), .o_rd_a(o_rd_a),
    .o_issue(o_issue), .o_busy(o_busy), .i_ld_valid(i_ld_valid),
    .o_wb_fp(o_wb_fp), .o_wb_int(o_wb_int), .o_illegal(o_illegal),
    .i_flush(i_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] f7, input logic [4:0] rd);
    i_valid  = 1'b1;
    i_ops    = 7'h53;
    i_funct7 = f7;
    i_funct3 = 3'b001;
    i_rs1_a  = 5'd1;
    i_rs2_a  = 5'd2;
    i_rd_a   = rd;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_valid = 1'b0; i_ops = 7'h0; i_funct7 = 7'h0; i_funct3 = 3'h0;
    i_rs1_a = 5'h0; i_rs2_a = 5'h0; i_rd_a = 5'h0; i_ld_valid = 1'b0; i_flush = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b exp 1", o_ready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if ({o_issue, o_illegal, o_wb_fp, o_wb_int} !== 4'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b exp 0000", {o_issue, o_illegal, o_wb_fp, o_wb_int}); end
    checks++; if ({o_ops, o_funct7, o_funct3, o_rs1_a, o_rs2_a, o_rd_a} !== 32'h0) begin errors++; $display("[TB] FAIL reset_fields got %h exp 0", {o_ops, o_funct7, o_funct3, o_rs1_a, o_rs2_a, o_rd_a}); end
  endtask

  task automatic test_fadd();
    offer(7'h00, 5'd5);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL fadd_ready got %b exp 1", o_ready); end
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (o_issue !== 1'b1) begin errors++; $display("[TB] FAIL fadd_issue got %b exp 1", o_issue); end
    checks++; if (o_busy !== 1'b1 || o_wb_fp !== 1'b0) begin errors++; $display("[TB] FAIL fadd_exec busy/wb got %b%b exp 10", o_busy, o_wb_fp); end
    checks++; if ({o_ops, o_funct7, o_funct3, o_rs1_a, o_rs2_a} !== {7'h53, 7'h00, 3'b001, 5'd1, 5'd2}) begin errors++; $display("[TB] FAIL fadd_fields got %h", {o_ops, o_funct7, o_funct3, o_rs1_a, o_rs2_a}); end
    tick();
    checks++; if (o_wb_fp !== 1'b1 || o_rd_a !== 5'd5) begin errors++; $display("[TB] FAIL fadd_wb got wb=%b rd=%0d exp wb=1 rd=5", o_wb_fp, o_rd_a); end
    checks++; if (o_issue !== 1'b0 || o_ready !== 1'b0 || o_wb_int !== 1'b0) begin errors++; $display("[TB] FAIL fadd_wb_side got issue=%b ready=%b int=%b exp 000", o_issue, o_ready, o_wb_int); end
    tick();
    checks++; if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_wb_fp !== 1'b0) begin errors++; $display("[TB] FAIL fadd_idle got ready=%b busy=%b wb=%b exp 1 0 0", o_ready, o_busy, o_wb_fp); end
  endtask

  task automatic test_illegal();
    offer(7'h00, 5'd9);
    i_ops = 7'h07;
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (o_illegal !== 1'b1 || o_issue !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_ops got ill=%b iss=%b busy=%b exp 1 0 0", o_illegal, o_issue, o_busy); end
    checks++; if (o_rd_a !== 5'd5 || o_ops !== 7'h53) begin errors++; $display("[TB] FAIL illegal_nolatch got rd=%0d ops=%h exp rd=5 ops=53", o_rd_a, o_ops); end
    offer(7'h10, 5'd9);
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (o_illegal !== 1'b1 || o_busy !== 1'b0 || o_rd_a !== 5'd5) begin errors++; $display("[TB] FAIL illegal_funct got ill=%b busy=%b rd=%0d exp 1 0 5", o_illegal, o_busy, o_rd_a); end
    tick();
    checks++; if (o_illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_pulse_len got %b exp 0", o_illegal); end
  endtask

  task automatic test_long_op();
    int busy_cnt;
    int wb_idx;
    offer(7'h0C, 5'd12);
    tick();
    i_valid = 1'b0;
    #1;
`ifdef FPU_CTRL_DIVSQRT_EN
    checks++; if (o_issue !== 1'b1) begin errors++; $display("[TB] FAIL fdiv_issue got %b exp 1", o_issue); end
    busy_cnt = 0;
    wb_idx = -1;
    for (int idx = 0; idx < 40 && o_busy; idx++) begin
      busy_cnt++;
      if (o_wb_fp && wb_idx < 0) wb_idx = idx;
      tick();
    end
    checks++; if (busy_cnt != 13) begin errors++; $display("[TB] FAIL fdiv_busy_cycles got %0d exp 13", busy_cnt); end
    checks++; if (wb_idx != 12) begin errors++; $display("[TB] FAIL fdiv_wb_cycle got %0d exp 12", wb_idx); end
    checks++; if (o_rd_a !== 5'd12 || o_ready !== 1'b1) begin errors++; $display("[TB] FAIL fdiv_end got rd=%0d ready=%b exp 12 1", o_rd_a, o_ready); end
`else
    checks++; if (o_illegal !== 1'b1 || o_issue !== 1'b0) begin errors++; $display("[TB] FAIL fdiv_illegal got ill=%b iss=%b exp 1 0", o_illegal, o_issue); end
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_rd_a !== 5'd5) begin errors++; $display("[TB] FAIL fdiv_dropped got busy=%b ready=%b rd=%0d exp 0 1 5", o_busy, o_ready, o_rd_a); end
    tick();
    checks++; if (o_illegal !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL fdiv_after got ill=%b busy=%b exp 0 0", o_illegal, o_busy); end
`endif
  endtask

  task automatic test_ld_conflict();
    offer(7'h08, 5'd7);
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (o_issue !== 1'b1) begin errors++; $display("[TB] FAIL fmul_issue got %b exp 1", o_issue); end
    tick();
    checks++; if (o_issue !== 1'b0 || o_wb_fp !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL fmul_exec2 got iss=%b wb=%b busy=%b exp 0 0 1", o_issue, o_wb_fp, o_busy); end
    tick();
    i_ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (o_wb_fp !== 1'b0 || o_busy !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("[TB] FAIL fmul_ld_hold%0d got wb=%b busy=%b ready=%b exp 0 1 0", k, o_wb_fp, o_busy, o_ready); end
      tick();
    end
    i_ld_valid = 1'b0;
    #1;
    checks++; if (o_wb_fp !== 1'b1 || o_rd_a !== 5'd7 || o_wb_int !== 1'b0) begin errors++; $display("[TB] FAIL fmul_wb got wb=%b rd=%0d int=%b exp 1 7 0", o_wb_fp, o_rd_a, o_wb_int); end
    tick();
    checks++; if (o_busy !== 1'b0 || o_wb_fp !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("[TB] FAIL fmul_idle got busy=%b wb=%b ready=%b exp 0 0 1", o_busy, o_wb_fp, o_ready); end
  endtask

  task automatic test_int_wb();
    offer(7'h50, 5'd3);
    i_ld_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (o_issue !== 1'b1 || o_wb_int !== 1'b0 || o_wb_fp !== 1'b0) begin errors++; $display("[TB] FAIL feq_exec got iss=%b int=%b fp=%b exp 1 0 0", o_issue, o_wb_int, o_wb_fp); end
    tick();
    checks++; if (o_wb_int !== 1'b1 || o_wb_fp !== 1'b0 || o_rd_a !== 5'd3) begin errors++; $display("[TB] FAIL feq_wb got int=%b fp=%b rd=%0d exp 1 0 3", o_wb_int, o_wb_fp, o_rd_a); end
    tick();
    checks++; if (o_busy !== 1'b0 || o_wb_int !== 1'b0) begin errors++; $display("[TB] FAIL feq_idle got busy=%b int=%b exp 0 0", o_busy, o_wb_int); end
    i_ld_valid = 1'b0;
  endtask

  task automatic test_flush();
    int wait_cycles;
`ifdef FPU_CTRL_DIVSQRT_EN
    offer(7'h2C, 5'd17);
    wait_cycles = 8;
`else
    offer(7'h08, 5'd17);
    wait_cycles = 0;
`endif
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < wait_cycles; k++) tick();
    i_flush = 1'b1;
    offer(7'h00, 5'd11);
    #1;
    checks++; if (o_issue !== 1'b0 || o_ready !== 1'b0 || o_wb_fp !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle got iss=%b ready=%b wb=%b exp 0 0 0", o_issue, o_ready, o_wb_fp); end
    tick();
    i_flush = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_wb_fp !== 1'b0 || o_ready !== 1'b1 || o_issue !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle got busy=%b wb=%b ready=%b iss=%b exp 0 0 1 0", o_busy, o_wb_fp, o_ready, o_issue); end
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (o_issue !== 1'b1 || o_rd_a !== 5'd11) begin errors++; $display("[TB] FAIL flush_next_accept got iss=%b rd=%0d exp 1 11", o_issue, o_rd_a); end
    tick();
    checks++; if (o_wb_fp !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_wb got %b exp 1", o_wb_fp); end
    tick();
  endtask

  task automatic test_back_to_back();
    offer(7'h04, 5'd13);
    tick();
    i_rd_a = 5'd14;
    #1;
    checks++; if (o_issue !== 1'b1 || o_rd_a !== 5'd13) begin errors++; $display("[TB] FAIL b2b_first got iss=%b rd=%0d exp 1 13", o_issue, o_rd_a); end
    tick();
    checks++; if (o_wb_fp !== 1'b1 || o_ready !== 1'b0 || o_rd_a !== 5'd13) begin errors++; $display("[TB] FAIL b2b_wb1 got wb=%b ready=%b rd=%0d exp 1 0 13", o_wb_fp, o_ready, o_rd_a); end
    tick();
    checks++; if (o_ready !== 1'b1 || o_issue !== 1'b0 || o_rd_a !== 5'd13) begin errors++; $display("[TB] FAIL b2b_gap got ready=%b iss=%b rd=%0d exp 1 0 13", o_ready, o_issue, o_rd_a); end
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (o_issue !== 1'b1 || o_rd_a !== 5'd14 || o_funct7 !== 7'h04) begin errors++; $display("[TB] FAIL b2b_second got iss=%b rd=%0d f7=%h exp 1 14 04", o_issue, o_rd_a, o_funct7); end
    tick();
    checks++; if (o_wb_fp !== 1'b1 || o_rd_a !== 5'd14) begin errors++; $display("[TB] FAIL b2b_wb2 got wb=%b rd=%0d exp 1 14", o_wb_fp, o_rd_a); end
    tick();
  endtask

  task automatic test_reset_mid();
`ifdef FPU_CTRL_DIVSQRT_EN
    offer(7'h0C, 5'd21);
`else
    offer(7'h08, 5'd21);
`endif
    tick();
    i_valid = 1'b0;
    tick();
    #1;
    checks++; if (o_busy !== 1'b1 || o_rd_a !== 5'd21) begin errors++; $display("[TB] FAIL rstmid_pre got busy=%b rd=%0d exp 1 21", o_busy, o_rd_a); end
    rst = 1'b0;
    #1;
    checks++; if ({o_busy, o_issue, o_wb_fp, o_wb_int, o_illegal} !== 5'b0 || o_rd_a !== 5'd0 || o_ops !== 7'd0) begin errors++; $display("[TB] FAIL rstmid_async got flags=%b rd=%0d ops=%h exp 0", {o_busy, o_issue, o_wb_fp, o_wb_int, o_illegal}, o_rd_a, o_ops); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_release got ready=%b busy=%b exp 1 0", o_ready, o_busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (o_wb_fp !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_nowb%0d got wb=%b busy=%b exp 0 0", k, o_wb_fp, o_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_illegal();
    test_long_op();
    test_ld_conflict();
    test_int_wb();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
